chu_vga_multi_sprite_core: RTL and testbench
============================================

# chu_vga_multi_sprite_core

Parametrised multi-sprite video core for one slot of the video daisy chain. It overlays NS independently positioned sprites on the incoming pixel stream, with fixed index priority, per-sprite bitmap select and horizontal flip. It latches per-frame sprite-to-sprite collision flags. It replaces single-sprite cores (player, ghost) where several sprites of one kind share bitmaps, and keeps the chain's 2-cycle per-core pixel latency.

## Interface
- CD, 12, colour depth of si_rgb/so_rgb/bitmap pixels
- NS, 4, number of sprites (1..8)
- SZ_LOG2, 4, sprite edge = 2^SZ_LOG2 pixels (square)
- NF, 4, bitmaps in shared store (power of 2, ≥2)
- KEY_COLOR, 0, transparent pixel value
- clk  in  1  system clock; one clock only
- reset  in  1  synchronous, active-high
- x, y  in  11 each  current pixel from frame counter
- cs  in  1  slot select
- write  in  1  write strobe, qualified by cs
- addr  in  14  slot word address
- wr_data  in  32  write data
- si_rgb  in  CD  upstream pixel
- so_rgb  out  CD  composited pixel
- collision  out  NS  per-sprite collision flags of the last complete frame

## Operation
- Write decode (cs && write):
  - addr[13]=1: bitmap write. Address = addr[log2(NF)+2*SZ_LOG2-1:0] = {bitmap, row, col}; data = wr_data[CD-1:0].
  - addr[13]=0: register write. Sprite index = addr[5:3], register = addr[2:0]. Sprite index ≥ NS is ignored.
- Registers per sprite:
  - 0 = x0 (wr_data[10:0])
  - 1 = y0 (wr_data[10:0])
  - 2 = ctrl: bit0 enable, bit1 hflip, bits[log2(NF)+7:8] bitmap select
  - 3..7 reserved, ignored.
- Global register at addr[13]=0, addr[5:0]=6'h3F: bit0 bypass. Bypass forces so_rgb = delayed si_rgb; collision flags are still tracked.
- Hit test per sprite: dx = x − x0 and dy = y − y0, computed in 12-bit modular arithmetic. Sprite covers (x,y) iff enable && dx < 2^SZ_LOG2 && dy < 2^SZ_LOG2 (unsigned). This clips naturally at the right and bottom screen edges.
- Column = hflip ? (2^SZ_LOG2−1−dx) : dx.
- Bitmap store: replicated once per sprite so all NS reads happen in parallel. Writes are broadcast to every replica.
- Compositing: an opaque pixel is a covered pixel whose bitmap value ≠ KEY_COLOR. The lowest-index opaque sprite wins; if none is opaque, output the delayed si_rgb.
- Collision:
  - Accumulator: when ≥2 sprites are opaque on the same pixel, OR their bits into coll_acc.
  - Frame boundary = x==0 && y==0 at input. At the boundary, collision <= coll_acc, and coll_acc is cleared to that pixel's own contribution.
  - Register writes never touch the flags.

## Timing
- Latency si_rgb/x/y → so_rgb: exactly 2 cycles, unconditionally (bypass included).
- Cycle 0: hit flags and bitmap addresses are formed combinationally; bitmap RAM is read synchronously.
- Cycle 1: RAM data, registered hit flags and si_rgb d1 are available; winner is selected.
- Cycle 2: so_rgb register updates.
- Register writes take effect for pixels entering the following cycle. A write on the same cycle as a pixel does not affect that pixel.
- Bitmap write and read to the same address in the same cycle: the read returns old data (read-first).
- Reset values:
  - so_rgb = 0, collision = 0, coll_acc = 0.
  - All x0/y0/ctrl = 0 (all sprites disabled), bypass = 0.
  - The delay pipeline is cleared.
  - Bitmap RAM is not reset.
- After reset, so_rgb = si_rgb delayed by 2 cycles once the pipeline fills.
- Reset mid-frame: accumulator is lost, and collision reads 0 until the next frame boundary.

## Structure
- Package chu_vga_multi_sprite_pkg holds:
  - register indices (REG_X0=0, REG_Y0=1, REG_CTRL=2, GLOBAL_ADDR=6'h3F)
  - ctrl bit positions
  - sprite_regs_t struct {x0, y0, en, hflip, bmp}
- Sub-module chu_sprite_bitmap_ram: simple dual-port, one write port, one registered read port, read-first. Instantiated NS times in a generate loop.
- Integration: the system's 2-stage frame_start/inc delay line remains valid because this core adds no extra latency beyond the chain's per-core 2 cycles.

## Test plan
- Reset, sprites disabled, si_rgb ramps 0..255 → so_rgb equals the same ramp 2 cycles later; collision = 0.
- Load bitmap 1 with all 12'hF00 and col 0 = KEY_COLOR. Sprite 0: x0=100, y0=50, bmp=1, en=1. Scan line y=50 → x=100 shows si_rgb, x=101..115 show F00, x=116 shows si_rgb.
- Same setup with hflip=1 → x=115 shows si_rgb (transparent), x=100..114 show F00.
- Sprite 0 (bmp 1, F00) and sprite 1 (bmp 2, 0F0) both at (200,200), overlapping → F00 output (index priority). collision = 2'b11 after the next x=0,y=0; returns to 0 one frame after sprite 1 is disabled.
- Sprite at x0=630 → pixels 630..639 drawn and no wrap onto the left edge of the next line. Sprite at x0=12'h7F8 (negative) → x=0..7 drawn.
- Bypass=1 with sprites enabled → so_rgb = si_rgb delayed 2 cycles, and collision is still set.

Source files
------------

// File: rtl/chu_vga_multi_sprite_pkg.sv
// Shared types and constants for the multi-sprite video core:
// register map, control bit positions and the per-sprite register record.
package chu_vga_multi_sprite_pkg;

  localparam int COORD_W = 11;
  localparam int CALC_W = 12;
  localparam int BMP_W = 8;

  typedef enum logic [2:0] {
    REG_X0   = 3'd0,
    REG_Y0   = 3'd1,
    REG_CTRL = 3'd2
  } sprite_reg_e;

  localparam logic [5:0] GLOBAL_ADDR = 6'h3F;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_HFLIP_BIT = 1;
  localparam int CTRL_BMP_LSB = 8;
  localparam int BYPASS_BIT = 0;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic               en;
    logic               hflip;
    logic [BMP_W-1:0]   bmp;
  } sprite_regs_t;

  // Origins are treated as signed so a sprite can start left of / above the screen.
  function automatic logic [CALC_W-1:0] sext_coord(input logic [COORD_W-1:0] v);
    return {v[COORD_W-1], v};
  endfunction

endpackage

// File: rtl/chu_vga_multi_sprite_core_if.sv
// Slot bus of the video daisy chain: select, write strobe, word address, data.
interface chu_vga_multi_sprite_core_if;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  modport master (output cs, write, addr, wr_data);
  modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/chu_sprite_bitmap_ram.sv
// Simple dual-port bitmap store: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module chu_sprite_bitmap_ram #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/chu_vga_multi_sprite_core.sv
// Multi-sprite overlay for one video chain slot: NS prioritised sprites,
// shared bitmaps, horizontal flip, per-frame collision flags, 2-cycle latency.
module chu_vga_multi_sprite_core
  import chu_vga_multi_sprite_pkg::*;
#(
  parameter int          CD        = 12,
  parameter int          NS        = 4,
  parameter int          SZ_LOG2   = 4,
  parameter int          NF        = 4,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COORD_W-1:0]         x_i,
  input  logic [COORD_W-1:0]         y_i,
  chu_vga_multi_sprite_core_if.slave bus,
  input  logic [CD-1:0]              si_rgb_i,
  output logic [CD-1:0]              so_rgb_o,
  output logic [NS-1:0]              collision_o
);

  localparam int NFW = $clog2(NF);
  localparam int AW = NFW + 2 * SZ_LOG2;

  sprite_regs_t regs_q [NS];
  sprite_regs_t regs_d [NS];
  logic bypass_q, bypass_d;

  logic reg_we_s, bmp_we_s;
  logic [CALC_W-1:0] dx_s [NS];
  logic [CALC_W-1:0] dy_s [NS];
  logic [SZ_LOG2-1:0] col_s [NS];
  logic [AW-1:0] raddr_s [NS];
  logic [CD-1:0] rdata_s [NS];
  logic [NS-1:0] hit_s;

  logic [NS-1:0] hit_q;
  logic [CD-1:0] si_d1_q;
  logic bound_d1_q, bypass_d1_q;

  logic [NS-1:0] opaque_s, contrib_s;
  logic [CD-1:0] win_rgb_s, so_rgb_d, so_rgb_q;
  logic [NS-1:0] coll_acc_d, coll_acc_q, collision_d, collision_q;
  logic unused_bus_s;

  assign reg_we_s = bus.cs && bus.write && !bus.addr[13];
  assign bmp_we_s = bus.cs && bus.write && bus.addr[13];
  assign unused_bus_s = ^{bus.addr, bus.wr_data};

  // Register-file write decode; sprite indices at or above NS fall through untouched.
  always_comb begin
    regs_d = regs_q;
    bypass_d = bypass_q;
    if (reg_we_s) begin
      if (bus.addr[5:0] == GLOBAL_ADDR) begin
        bypass_d = bus.wr_data[BYPASS_BIT];
      end else begin
        for (int s = 0; s < NS; s++) begin
          if (bus.addr[5:3] == 3'(s)) begin
            case (sprite_reg_e'(bus.addr[2:0]))
              REG_X0: regs_d[s].x0 = bus.wr_data[COORD_W-1:0];
              REG_Y0: regs_d[s].y0 = bus.wr_data[COORD_W-1:0];
              REG_CTRL: begin
                regs_d[s].en    = bus.wr_data[CTRL_EN_BIT];
                regs_d[s].hflip = bus.wr_data[CTRL_HFLIP_BIT];
                regs_d[s].bmp   = bus.wr_data[CTRL_BMP_LSB +: BMP_W];
              end
              default: regs_d[s] = regs_q[s];
            endcase
          end else begin
            regs_d[s] = regs_q[s];
          end
        end
      end
    end else begin
      bypass_d = bypass_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        regs_q[s] <= '0;
      end
      bypass_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      bypass_q <= bypass_d;
    end
  end

  // Stage 0: modular offsets give right/bottom clipping and negative origins for free.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      dx_s[s] = {1'b0, x_i} - sext_coord(regs_q[s].x0);
      dy_s[s] = {1'b0, y_i} - sext_coord(regs_q[s].y0);
      hit_s[s] = regs_q[s].en && (dx_s[s][CALC_W-1:SZ_LOG2] == '0)
                 && (dy_s[s][CALC_W-1:SZ_LOG2] == '0);
      col_s[s] = regs_q[s].hflip ? ~dx_s[s][SZ_LOG2-1:0] : dx_s[s][SZ_LOG2-1:0];
      raddr_s[s] = {regs_q[s].bmp[NFW-1:0], dy_s[s][SZ_LOG2-1:0], col_s[s]};
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_bmp
    chu_sprite_bitmap_ram #(
      .DW(CD),
      .AW(AW)
    ) u_ram (
      .clk     (clk),
      .we_i    (bmp_we_s),
      .waddr_i (bus.addr[AW-1:0]),
      .wdata_i (bus.wr_data[CD-1:0]),
      .raddr_i (raddr_s[g]),
      .rdata_o (rdata_s[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q       <= '0;
      si_d1_q     <= '0;
      bound_d1_q  <= 1'b0;
      bypass_d1_q <= 1'b0;
    end else begin
      hit_q       <= hit_s;
      si_d1_q     <= si_rgb_i;
      bound_d1_q  <= (x_i == 11'd0) && (y_i == 11'd0);
      bypass_d1_q <= bypass_q;
    end
  end

  // Stage 1: lowest index opaque sprite wins; collisions need two or more opaque.
  always_comb begin
    opaque_s = '0;
    win_rgb_s = si_d1_q;
    for (int s = NS - 1; s >= 0; s--) begin
      opaque_s[s] = hit_q[s] && (rdata_s[s] != KEY_COLOR);
      win_rgb_s = opaque_s[s] ? rdata_s[s] : win_rgb_s;
    end
    contrib_s = ((opaque_s & (opaque_s - NS'(1))) != '0) ? opaque_s : '0;
    so_rgb_d = bypass_d1_q ? si_d1_q : win_rgb_s;
    if (bound_d1_q) begin
      collision_d = coll_acc_q;
      coll_acc_d = contrib_s;
    end else begin
      collision_d = collision_q;
      coll_acc_d = coll_acc_q | contrib_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      so_rgb_q    <= '0;
      coll_acc_q  <= '0;
      collision_q <= '0;
    end else begin
      so_rgb_q    <= so_rgb_d;
      coll_acc_q  <= coll_acc_d;
      collision_q <= collision_d;
    end
  end

  assign so_rgb_o = so_rgb_q;
  assign collision_o = collision_q;

endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
// Directed bench for chu_vga_multi_sprite_core with hand-computed expectations.
module tb_chu_vga_multi_sprite_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic [11:0] si, so;
  logic [3:0]  coll;
  int checks = 0;
  int failures = 0;

  chu_vga_multi_sprite_core_if bus_if ();

  chu_vga_multi_sprite_core dut (
    .clk         (clk),
    .reset       (reset),
    .x_i         (x),
    .y_i         (y),
    .bus         (bus_if),
    .si_rgb_i    (si),
    .so_rgb_o    (so),
    .collision_o (coll)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus_if.cs = 1'b1;
    bus_if.write = 1'b1;
    bus_if.addr = a;
    bus_if.wr_data = d;
    step();
    bus_if.cs = 1'b0;
    bus_if.write = 1'b0;
  endtask

  function automatic logic [13:0] rad(input int s, input int r);
    return 14'(s * 8 + r);
  endfunction

  task automatic load_bmp(input int b, input logic [11:0] rgb, input bit key_col0);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        wr(14'h2000 | 14'(b * 256 + r * 16 + c), (key_col0 && c == 0) ? 32'd0 : {20'd0, rgb});
      end
    end
  endtask

  task automatic pix(input int px, input int py, input logic [11:0] rgb,
                     input logic [11:0] exp, input string nm);
    x = 11'(px);
    y = 11'(py);
    si = rgb;
    step();
    step();
    checks++;
    if (so !== exp) begin
      failures++;
      $display("FAIL %s: so_rgb=%h expected %h", nm, so, exp);
    end
    x = 11'd1000;
    y = 11'd1000;
  endtask

  task automatic frame(input logic [3:0] exp, input string nm);
    x = 11'd0;
    y = 11'd0;
    step();
    x = 11'd1000;
    y = 11'd1000;
    step();
    checks++;
    if (coll !== exp) begin
      failures++;
      $display("FAIL %s: collision=%b expected %b", nm, coll, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    si = 12'hABC;
    x = 11'd5;
    y = 11'd5;
    bus_if.cs = 1'b0;
    bus_if.write = 1'b0;
    bus_if.addr = '0;
    bus_if.wr_data = '0;
    repeat (3) step();
    checks++;
    if (so !== 12'h000) begin
      failures++;
      $display("FAIL reset_so: so_rgb=%h expected 000", so);
    end
    checks++;
    if (coll !== 4'b0000) begin
      failures++;
      $display("FAIL reset_coll: collision=%b expected 0000", coll);
    end
  endtask

  task automatic test_ramp();
    logic [11:0] exp;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      x = 11'd400;
      y = 11'd400;
      si = 12'(i);
      exp = (i < 2) ? 12'h000 : 12'(i - 2);
      checks++;
      if (so !== exp) begin
        failures++;
        $display("FAIL ramp[%0d]: so_rgb=%h expected %h", i, so, exp);
      end
      step();
    end
    checks++;
    if (coll !== 4'b0000) begin
      failures++;
      $display("FAIL ramp_coll: collision=%b expected 0000", coll);
    end
  endtask

  task automatic test_sprite();
    x = 11'd1000;
    y = 11'd1000;
    load_bmp(1, 12'hF00, 1'b1);
    load_bmp(2, 12'h0F0, 1'b0);
    wr(rad(0, 0), 32'd100);
    wr(rad(0, 1), 32'd50);
    wr(rad(0, 2), 32'h101);
    pix(99, 50, 12'h123, 12'h123, "left_of_sprite");
    pix(100, 50, 12'h123, 12'h123, "key_col0");
    pix(101, 50, 12'h123, 12'hF00, "col1");
    pix(115, 50, 12'h123, 12'hF00, "col15");
    pix(116, 50, 12'h123, 12'h123, "right_of_sprite");
    pix(108, 65, 12'h123, 12'hF00, "last_row");
    pix(108, 66, 12'h123, 12'h123, "below_sprite");
    pix(108, 49, 12'h123, 12'h123, "above_sprite");
  endtask

  task automatic test_hflip();
    wr(rad(0, 2), 32'h103);
    pix(115, 50, 12'h123, 12'h123, "hflip_key");
    pix(100, 50, 12'h123, 12'hF00, "hflip_left");
    pix(114, 50, 12'h123, 12'hF00, "hflip_col14");
  endtask

  task automatic test_priority_collision();
    frame(4'b0000, "coll_start");
    wr(rad(0, 2), 32'h000);
    wr(rad(0, 0), 32'd200);
    wr(rad(0, 1), 32'd200);
    wr(rad(1, 0), 32'd200);
    wr(rad(1, 1), 32'd200);
    wr(rad(1, 2), 32'h201);
    pix(205, 205, 12'h123, 12'h0F0, "sprite1_alone");
    wr(rad(0, 2), 32'h101);
    pix(205, 205, 12'h123, 12'hF00, "priority");
    pix(200, 205, 12'h123, 12'h0F0, "fallthrough");
    frame(4'b0011, "coll_set");
    wr(rad(1, 2), 32'h000);
    checks++;
    if (coll !== 4'b0011) begin
      failures++;
      $display("FAIL coll_after_write: collision=%b expected 0011", coll);
    end
    pix(205, 205, 12'h123, 12'hF00, "sprite0_alone");
    frame(4'b0000, "coll_clear");
  endtask

  task automatic test_edges();
    wr(rad(0, 0), 32'd630);
    wr(rad(0, 1), 32'd300);
    wr(rad(0, 2), 32'h201);
    pix(630, 300, 12'h123, 12'h0F0, "right_first");
    pix(639, 300, 12'h123, 12'h0F0, "right_last");
    pix(629, 300, 12'h123, 12'h123, "right_before");
    pix(0, 301, 12'h123, 12'h123, "no_wrap");
    wr(rad(0, 0), 32'h7F8);
    pix(0, 300, 12'h123, 12'h0F0, "neg_x0_first");
    pix(7, 300, 12'h123, 12'h0F0, "neg_x0_last");
    pix(8, 300, 12'h123, 12'h123, "neg_x0_after");
  endtask

  task automatic test_back_to_back();
    wr(rad(0, 0), 32'd200);
    wr(rad(0, 1), 32'd200);
    x = 11'd205;
    y = 11'd205;
    si = 12'h456;
    bus_if.cs = 1'b1;
    bus_if.write = 1'b1;
    bus_if.addr = rad(0, 2);
    bus_if.wr_data = 32'd0;
    step();
    bus_if.cs = 1'b0;
    bus_if.write = 1'b0;
    step();
    checks++;
    if (so !== 12'h0F0) begin
      failures++;
      $display("FAIL same_cycle_write: so_rgb=%h expected 0f0", so);
    end
    x = 11'd1000;
    y = 11'd1000;
    step();
    checks++;
    if (so !== 12'h456) begin
      failures++;
      $display("FAIL write_effect: so_rgb=%h expected 456", so);
    end
  endtask

  task automatic test_bypass();
    logic [11:0] exp;
    wr(rad(0, 2), 32'h101);
    wr(rad(1, 2), 32'h201);
    wr(14'h003F, 32'd1);
    frame(4'b0000, "coll_pre_bypass");
    pix(205, 205, 12'h789, 12'h789, "bypass_pixel");
    for (int i = 0; i < 6; i++) begin
      x = 11'd205;
      y = 11'd205;
      si = 12'h700 + 12'(i);
      if (i >= 2) begin
        exp = 12'h700 + 12'(i - 2);
        checks++;
        if (so !== exp) begin
          failures++;
          $display("FAIL bypass_ramp[%0d]: so_rgb=%h expected %h", i, so, exp);
        end
      end
      step();
    end
    frame(4'b0011, "bypass_coll");
    wr(14'h003F, 32'd0);
    pix(205, 205, 12'h123, 12'hF00, "bypass_off");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_sprite();
    test_hflip();
    test_priority_collision();
    test_edges();
    test_back_to_back();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
